sega_pad_responder: RTL and testbench



---
 rtl/sega_pad_responder_if.sv | 25 ++
 rtl/sega_pad_responder.sv | 133 +++++++++++++
 tb/tb_sega_pad_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sega_pad_responder_if.sv
// Signal bundle between a DB9 host reader (master) and the emulated pad (slave).
// Every line is level-based; the pad has no valid/ready handshake to speak of.
interface sega_pad_responder_if;
    logic        select_i;
    logic [11:0] buttons_i;
    logic        six_button_en_i;
    logic [5:0]  pad_o;
    logic [2:0]  phase_o;

    modport master (
        output select_i,
        output buttons_i,
        output six_button_en_i,
        input  pad_o,
        input  phase_o
    );

    modport slave (
        input  select_i,
        input  buttons_i,
        input  six_button_en_i,
        output pad_o,
        output phase_o
    );
endinterface

// File: rtl/sega_pad_responder.sv
// Device end of a Mega Drive / Master System DB9 joypad: follows select toggles
// through the 3/6-button phase sequence and drives the multiplexed return lines.
module sega_pad_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 72000
) (
    input  logic                 clk_i,
    input  logic                 res_n_i,
    sega_pad_responder_if.slave  bus
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        PH_0 = 3'd0,
        PH_1 = 3'd1,
        PH_2 = 3'd2,
        PH_3 = 3'd3,
        PH_4 = 3'd4,
        PH_5 = 3'd5,
        PH_6 = 3'd6,
        PH_7 = 3'd7
    } phase_e;

    logic [1:0]       sync_q;
    logic             sel_s;
    logic             sel_d_q;
    logic             edge_ev;
    logic             expire;
    phase_e           phase_q;
    phase_e           phase_d;
    logic [2:0]       phase_inc;
    logic [CNT_W-1:0] tmo_q;
    logic [CNT_W-1:0] tmo_d;
    logic [5:0]       pad_q;
    logic [5:0]       pad_d;

    logic btn_u, btn_d, btn_l, btn_r, btn_b, btn_c, btn_a, btn_start;
    logic btn_z, btn_y, btn_x, btn_mode;

    assign btn_u     = bus.buttons_i[0];
    assign btn_d     = bus.buttons_i[1];
    assign btn_l     = bus.buttons_i[2];
    assign btn_r     = bus.buttons_i[3];
    assign btn_b     = bus.buttons_i[4];
    assign btn_c     = bus.buttons_i[5];
    assign btn_a     = bus.buttons_i[6];
    assign btn_start = bus.buttons_i[7];
    assign btn_z     = bus.buttons_i[8];
    assign btn_y     = bus.buttons_i[9];
    assign btn_x     = bus.buttons_i[10];
    assign btn_mode  = bus.buttons_i[11];

    // Select idles high, so all three copies reset high; a low select at
    // release then shows up as an ordinary falling edge.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sync_q  <= 2'b11;
            sel_d_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], bus.select_i};
            sel_d_q <= sel_s;
        end
    end

    assign sel_s     = sync_q[1];
    assign edge_ev   = sel_s ^ sel_d_q;
    assign expire    = (tmo_q == CNT_LAST) && !edge_ev;
    assign phase_inc = phase_q + 3'd1;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            phase_q <= PH_0;
            tmo_q   <= '0;
            pad_q   <= 6'b111111;
        end else begin
            phase_q <= phase_d;
            tmo_q   <= tmo_d;
            pad_q   <= pad_d;
        end
    end

    // An edge on the expiry cycle takes priority, so a host polling exactly
    // at the timeout still advances rather than being thrown back.
    always_comb begin
        phase_d = phase_q;
        tmo_d   = tmo_q;
        if (edge_ev) begin
            phase_d = phase_e'(phase_inc);
            tmo_d   = '0;
        end else if (expire) begin
            phase_d = sel_s ? PH_0 : PH_1;
            tmo_d   = '0;
        end else if (tmo_q != CNT_MAX) begin
            tmo_d   = tmo_q + CNT_W'(1);
        end
    end

    // Lines are {p9, p6, right, left, down, up}, low when pressed.
    always_comb begin
        pad_d = ~{btn_c, btn_b, btn_r, btn_l, btn_d, btn_u};
        unique case (phase_q)
            PH_1, PH_3: begin
                pad_d = {~btn_start, ~btn_a, 2'b00, ~btn_d, ~btn_u};
            end
            PH_5: begin
                if (bus.six_button_en_i) begin
                    pad_d = {~btn_start, ~btn_a, 4'b0000};
                end else begin
                    pad_d = {~btn_start, ~btn_a, 2'b00, ~btn_d, ~btn_u};
                end
            end
            PH_6: begin
                if (bus.six_button_en_i) begin
                    pad_d = ~{btn_c, btn_b, btn_mode, btn_x, btn_y, btn_z};
                end
            end
            PH_7: begin
                if (bus.six_button_en_i) begin
                    pad_d = {~btn_start, ~btn_a, 4'b1111};
                end else begin
                    pad_d = {~btn_start, ~btn_a, 2'b00, ~btn_d, ~btn_u};
                end
            end
            default: begin
                pad_d = ~{btn_c, btn_b, btn_r, btn_l, btn_d, btn_u};
            end
        endcase
    end

    assign bus.pad_o   = pad_q;
    assign bus.phase_o = phase_q;
endmodule

// File: tb/tb_sega_pad_responder.sv
// Bench for sega_pad_responder: two instances (long and short timeout) share
// one stimulus stream and are compared against a phase-history pad model.
`timescale 1ns/1ps
module tb_sega_pad_responder;
    localparam int T_A = 1000;
    localparam int T_B = 100;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel = 1'b1;
    logic [11:0] btn = '0;
    logic        en  = 1'b0;

    sega_pad_responder_if bus_a ();
    sega_pad_responder_if bus_b ();

    assign bus_a.select_i        = sel;
    assign bus_a.buttons_i       = btn;
    assign bus_a.six_button_en_i = en;
    assign bus_b.select_i        = sel;
    assign bus_b.buttons_i       = btn;
    assign bus_b.six_button_en_i = en;

    sega_pad_responder #(.TIMEOUT_CYCLES(T_A)) dut_a (
        .clk_i   (clk),
        .res_n_i (rst_n),
        .bus     (bus_a)
    );

    sega_pad_responder #(.TIMEOUT_CYCLES(T_B)) dut_b (
        .clk_i   (clk),
        .res_n_i (rst_n),
        .bus     (bus_b)
    );

    wire [17:0] obs = {bus_a.phase_o, bus_a.pad_o, bus_b.phase_o, bus_b.pad_o};

    // ---------------- reference model ----------------
    int exp_ph_a = 0;
    int exp_ph_b = 0;
    int last_cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;

    // A 3-button pad never leaves the lower half of the sequence, so phases
    // 5..7 read like 1..3 when the 6-button extension is off.
    function automatic logic [5:0] model_pad(int ph, logic [11:0] b, logic six);
        int         eff;
        logic [5:0] pressed;
        eff = (!six && ph >= 5) ? ph - 4 : ph;
        if (eff == 6)          pressed = {b[5], b[4], b[11], b[10], b[9], b[8]};
        else if (eff == 5)     pressed = {b[7], b[6], 4'b1111};
        else if (eff == 7)     pressed = {b[7], b[6], 4'b0000};
        else if (eff % 2 == 1) pressed = {b[7], b[6], 2'b11, b[1], b[0]};
        else                   pressed = {b[5], b[4], b[3], b[2], b[1], b[0]};
        return ~pressed;
    endfunction

    // gap = clock cycles since the previous select toggle; a silence longer
    // than the timeout drops the pad back to the start of its sequence.
    function automatic int model_advance(int ph, int gap, int tmo, logic level);
        int p;
        p = ph;
        if (gap > tmo) p = level ? 0 : 1;
        return (p + 1) % 8;
    endfunction

    function automatic logic [17:0] model_view();
        return {3'(exp_ph_a), model_pad(exp_ph_a, btn, en),
                3'(exp_ph_b), model_pad(exp_ph_b, btn, en)};
    endfunction

    // ---------------- driver tasks (all start just after a negedge) ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle_select();
        int gap;
        gap      = cyc - last_cyc;
        exp_ph_a = model_advance(exp_ph_a, gap, T_A, sel);
        exp_ph_b = model_advance(exp_ph_b, gap, T_B, sel);
        sel      = ~sel;
        last_cyc = cyc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n    = 1'b1;
        exp_ph_a = sel ? 0 : 1;
        exp_ph_b = sel ? 0 : 1;
        last_cyc = cyc;
        wait_cycles(4);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sel = 1'b1; btn = '0; en = 1'b0;
        wait_cycles(2);
        n_checks++;
        if (obs !== model_view()) $display("FAIL reset_held: obs=%h exp=%h", obs, model_view());
        else n_pass++;
        rst_n    = 1'b1;
        last_cyc = cyc;
        wait_cycles(4);
        n_checks++;
        if (obs !== model_view()) $display("FAIL reset_idle: obs=%h exp=%h", obs, model_view());
        else n_pass++;
        btn = 12'h011;
        #1;
        n_checks++;
        if (bus_a.pad_o !== 6'b111111) $display("FAIL button_no_comb: pad=%b exp=111111", bus_a.pad_o);
        else n_pass++;
        wait_cycles(1);
        n_checks++;
        if (obs !== model_view() || bus_a.pad_o !== 6'b101110)
            $display("FAIL button_latency: obs=%h exp=%h", obs, model_view());
        else n_pass++;
    endtask

    task automatic test_select_low();
        btn = 12'h0C4;
        toggle_select();
        wait_cycles(4);
        n_checks++;
        if (obs !== model_view() || bus_a.pad_o !== 6'b000011 || bus_a.phase_o !== 3'd1)
            $display("FAIL select_low: obs=%h exp=%h", obs, model_view());
        else n_pass++;
    endtask

    task automatic test_sequence(input logic six);
        logic [5:0] tbl [8];
        if (six) tbl = '{6'b111111, 6'b110011, 6'b111111, 6'b110011,
                         6'b111111, 6'b110000, 6'b110111, 6'b111111};
        else     tbl = '{6'b111111, 6'b110011, 6'b111111, 6'b110011,
                         6'b111111, 6'b110011, 6'b111111, 6'b110011};
        sel = 1'b1; btn = 12'h800; en = six;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            toggle_select();
            wait_cycles(4);
            n_checks++;
            if (obs !== model_view() || bus_a.pad_o !== tbl[i % 8] || bus_a.phase_o !== 3'(i % 8))
                $display("FAIL sequence six=%0d edge=%0d: obs=%h exp=%h pad_req=%b",
                         six, i, obs, model_view(), tbl[i % 8]);
            else n_pass++;
            wait_cycles(96);
        end
    endtask

    task automatic test_timeout();
        sel = 1'b1; btn = '0; en = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            toggle_select();
            wait_cycles(10);
        end
        n_checks++;
        if (obs !== model_view()) $display("FAIL timeout_phase3: obs=%h exp=%h", obs, model_view());
        else n_pass++;
        wait_cycles(100);
        n_checks++;
        if (bus_b.phase_o !== 3'(sel ? 0 : 1) || bus_a.phase_o !== 3'(exp_ph_a))
            $display("FAIL timeout_expired: a=%0d b=%0d exp_a=%0d exp_b=1",
                     bus_a.phase_o, bus_b.phase_o, exp_ph_a);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            toggle_select();
            wait_cycles(4);
            n_checks++;
            if (obs !== model_view() || bus_b.pad_o === 6'b110000)
                $display("FAIL timeout_restart%0d: obs=%h exp=%h", i, obs, model_view());
            else n_pass++;
            wait_cycles(6);
        end
    endtask

    task automatic test_expiry_edge();
        sel = 1'b1; btn = 12'h0F0; en = 1'b1;
        do_reset();
        toggle_select();
        wait_cycles(100);
        toggle_select();
        wait_cycles(4);
        n_checks++;
        if (obs !== model_view() || bus_b.phase_o !== 3'd2)
            $display("FAIL expiry_edge_wins: obs=%h exp=%h", obs, model_view());
        else n_pass++;
        wait_cycles(97);
        toggle_select();
        wait_cycles(4);
        n_checks++;
        if (obs !== model_view() || bus_b.phase_o !== 3'd1)
            $display("FAIL expiry_one_late: obs=%h exp=%h", obs, model_view());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        sel = 1'b1; btn = '0; en = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            toggle_select();
            wait_cycles(10);
        end
        n_checks++;
        if (obs !== model_view() || bus_a.phase_o !== 3'd5)
            $display("FAIL reset_mid_pre: obs=%h exp=%h", obs, model_view());
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== {3'd0, 6'b111111, 3'd0, 6'b111111})
            $display("FAIL reset_mid_async: obs=%h exp=%h", obs, {3'd0, 6'b111111, 3'd0, 6'b111111});
        else n_pass++;
        wait_cycles(2);
        rst_n    = 1'b1;
        exp_ph_a = 1;
        exp_ph_b = 1;
        last_cyc = cyc;
        wait_cycles(4);
        n_checks++;
        if (obs !== model_view() || bus_a.pad_o !== 6'b110011)
            $display("FAIL reset_mid_release: obs=%h exp=%h", obs, model_view());
        else n_pass++;
    endtask

    task automatic test_random();
        int hold;
        sel = 1'b1; btn = '0; en = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       hold = 100;
                1:       hold = 101;
                default: hold = $urandom_range(5, 140);
            endcase
            btn = 12'($urandom);
            en  = 1'($urandom);
            toggle_select();
            wait_cycles(4);
            n_checks++;
            if (obs !== model_view()) $display("FAIL random_edge%0d: obs=%h exp=%h", i, obs, model_view());
            else n_pass++;
            btn = 12'($urandom);
            en  = 1'($urandom);
            wait_cycles(1);
            n_checks++;
            if (obs !== model_view()) $display("FAIL random_btn%0d: obs=%h exp=%h", i, obs, model_view());
            else n_pass++;
            wait_cycles(hold - 5);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_select_low();
        test_sequence(1'b1);
        test_sequence(1'b0);
        test_timeout();
        test_expiry_edge();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
